rrv64_clkgate_ctrl: RTL and testbench

- Enable-side controller for the L1D clock-gate cell. Watches L1D activity and drives the gate cell's functional and scan enables.
- Gates the clock after a programmable idle window. Re-enables it on a wake request, with a settle window before reporting ready.
- Runs on the free-running (ungated) clock, at the gate cell's input.

---
 rtl/rrv64_clkgate_ctrl.sv | 134 +++++++++++++
 tb/tb_rrv64_clkgate_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rrv64_clkgate_ctrl.sv
// rrv64_clkgate_ctrl
// Enable-side controller for the L1D clock-gate cell. It watches L1D activity,
// gates the clock after a programmable idle window, re-enables it on any wake
// source, and holds ready_o low for a settle window before the gated clock is
// reported usable. Runs on the free-running clock at the gate cell's input.
module rrv64_clkgate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int STAT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              busy_i,
    input  logic              wake_req_i,
    input  logic              gate_allow_i,
    input  logic              scan_mode_i,
    output logic              clk_enable_o,
    output logic              clk_senable_o,
    output logic              ready_o,
    output logic              gated_o,
    output logic [STAT_W-1:0] gate_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAT_W-1:0]  gate_cnt_q;
    logic               gate_entry;
    logic               idle;
    logic               clk_enable_q;
    logic               ready_q;
    logic               gated_q;

    // The gate may only close when nothing needs the clock and gating is permitted.
    assign idle = !busy_i && !wake_req_i && gate_allow_i && !scan_mode_i;

    // Next-state and counter decode for the idle / gated / settle sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        gate_entry = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (idle) begin
                    state_d = ST_COUNT;
                    cnt_d   = IDLE_LOAD;
                end
            end
            ST_COUNT: begin
                // Any wake source, even on the terminal count, abandons the window.
                if (!idle) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    state_d    = ST_GATED;
                    gate_entry = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GATED: begin
                if (!idle) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Inputs are ignored: a started wake always runs to completion.
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs registered from the next state so they change with the edge that moves the FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_enable_q <= 1'b1;
            ready_q      <= 1'b1;
            gated_q      <= 1'b0;
        end else begin
            clk_enable_q <= (state_d != ST_GATED);
            ready_q      <= (state_d == ST_RUN) || (state_d == ST_COUNT);
            gated_q      <= (state_d == ST_GATED);
        end
    end

    // Saturating count of entries into the gated state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_cnt_q <= '0;
        end else if (gate_entry && (gate_cnt_q != '1)) begin
            gate_cnt_q <= gate_cnt_q + STAT_W'(1);
        end
    end

    // Scan enable bypasses the FSM entirely so scan shifting never depends on state or reset.
    assign clk_senable_o = scan_mode_i;
    assign clk_enable_o  = clk_enable_q;
    assign ready_o       = ready_q;
    assign gated_o       = gated_q;
    assign gate_cnt_o    = gate_cnt_q;

endmodule

// File: tb/tb_rrv64_clkgate_ctrl.sv
// Testbench for rrv64_clkgate_ctrl: directed scenarios plus random traffic,
// checked through a scoreboard fed by a streak-length reference model.
module tb_rrv64_clkgate_ctrl;

    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 2;
    localparam int CNT_W       = 8;
    localparam int STAT_W      = 2;
    localparam int STAT_MAX    = (1 << STAT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              busy_i = 1'b1;
    logic              wake_req_i = 1'b0;
    logic              gate_allow_i = 1'b0;
    logic              scan_mode_i = 1'b0;
    logic              clk_enable_o;
    logic              clk_senable_o;
    logic              ready_o;
    logic              gated_o;
    logic [STAT_W-1:0] gate_cnt_o;

    rrv64_clkgate_ctrl #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (CNT_W),
        .STAT_W      (STAT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .busy_i        (busy_i),
        .wake_req_i    (wake_req_i),
        .gate_allow_i  (gate_allow_i),
        .scan_mode_i   (scan_mode_i),
        .clk_enable_o  (clk_enable_o),
        .clk_senable_o (clk_senable_o),
        .ready_o       (ready_o),
        .gated_o       (gated_o),
        .gate_cnt_o    (gate_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        en;
        logic        sen;
        logic        rdy;
        logic        gtd;
        logic [STAT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: counts the current streak of idle samples and the
    // remaining settle edges after a wake; no notion of the DUT's states.
    bit m_gated;
    int m_wake_left;
    int m_idle_run;
    int m_entries;

    function automatic void model_reset();
        m_gated     = 1'b0;
        m_wake_left = 0;
        m_idle_run  = 0;
        m_entries   = 0;
    endfunction

    function automatic void model_edge(bit rst, bit busy, bit wake, bit allow, bit scan);
        bit idle;
        if (rst) begin
            model_reset();
            return;
        end
        idle = !busy && !wake && allow && !scan;
        if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_gated) begin
            if (!idle) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_CYCLES;
            end
        end else if (idle) begin
            // Clock gates on the sample after IDLE_CYCLES consecutive idle samples.
            m_idle_run++;
            if (m_idle_run > IDLE_CYCLES) begin
                m_gated    = 1'b1;
                m_idle_run = 0;
                if (m_entries < STAT_MAX) m_entries++;
            end
        end else begin
            m_idle_run = 0;
        end
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.en  = !m_gated;
        e.sen = scan_mode_i;
        e.rdy = !m_gated && (m_wake_left == 0);
        e.gtd = m_gated;
        e.cnt = STAT_W'(m_entries);
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs away from the edge, advance the model at the edge.
    task automatic step(input string tag, input bit rst, input bit busy, input bit wake,
                        input bit allow, input bit scan);
        @(negedge clk_i);
        rst_i        = rst;
        busy_i       = busy;
        wake_req_i   = wake;
        gate_allow_i = allow;
        scan_mode_i  = scan;
        @(posedge clk_i);
        model_edge(rst, busy, wake, allow, scan);
        push_exp(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Reset asserted between edges; outputs must react before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        model_reset();
        push_exp(tag);
        @(posedge clk_i);
        model_edge(1'b1, busy_i, wake_req_i, gate_allow_i, scan_mode_i);
        push_exp(tag);
    endtask

    task automatic check(input string tag, input string field, input logic [STAT_W-1:0] act,
                         input logic [STAT_W-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s vector %0d at %0t: got %0d, expected %0d",
                     tag, field, vectors, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid one time unit after every clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i or posedge rst_i);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check(e.tag, "clk_enable_o",  STAT_W'(clk_enable_o),  STAT_W'(e.en));
                check(e.tag, "clk_senable_o", STAT_W'(clk_senable_o), STAT_W'(e.sen));
                check(e.tag, "ready_o",       STAT_W'(ready_o),       STAT_W'(e.rdy));
                check(e.tag, "gated_o",       STAT_W'(gated_o),       STAT_W'(e.gtd));
                check(e.tag, "gate_cnt_o",    gate_cnt_o,             e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Continuous idle gates after edge IDLE_CYCLES.
        idle_steps("idle_gate", IDLE_CYCLES + 4);

        // Wake request held until ready, then released.
        for (int i = 0; i < WAKE_CYCLES + 1; i++) step("wake", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("wake_busy", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Idle window broken by one busy sample restarts the count.
        idle_steps("partial", 10);
        step("partial_busy", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps("restart", IDLE_CYCLES + 3);

        // Terminal-edge wake source must abort gating.
        step("reopen", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < WAKE_CYCLES + 2; i++) step("reopen", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps("terminal", IDLE_CYCLES);
        step("terminal_wake", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // No permission: never gates; dropping permission while gated wakes.
        for (int i = 0; i < 25; i++) step("no_allow", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_steps("allow_gate", IDLE_CYCLES + 2);
        for (int i = 0; i < 5; i++) step("allow_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Scan mode forces exit and blocks re-entry.
        idle_steps("scan_gate", IDLE_CYCLES + 2);
        for (int i = 0; i < 25; i++) step("scan", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Async reset mid-GATED and mid-WAKE.
        idle_steps("rst_gated", IDLE_CYCLES + 2);
        async_reset("rst_gated");
        idle_steps("rst_wake", IDLE_CYCLES + 2);
        step("rst_wake", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        async_reset("rst_wake");

        // Five gate entries saturate a two-bit statistics counter.
        for (int n = 0; n < 5; n++) begin
            idle_steps("saturate", IDLE_CYCLES + 2);
            for (int i = 0; i < WAKE_CYCLES + 2; i++) step("saturate", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        // Random traffic, biased toward idle so gating occurs regularly.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset("rand_rst");
            end else begin
                step("random", 1'b0,
                     $urandom_range(0, 31) == 0,
                     $urandom_range(0, 63) == 0,
                     $urandom_range(0, 63) != 0,
                     $urandom_range(0, 127) == 0);
            end
        end

        @(negedge clk_i);
        @(negedge clk_i);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
